// File: rtl/spectrum_uart_framer.sv
// Frames one spectrum per request onto async_transmitter: sync, length, NUM_BINS bins, checksum.
// Define FRAMER_CSUM_EN to append the XOR checksum byte; otherwise the frame ends after the last bin.
module spectrum_uart_framer #(
  parameter int unsigned NUM_BINS  = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_req,
  output logic [ADDR_W-1:0] bin_addr,
  input  logic [7:0]        bin_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    StIdle, StSend, StAccept, StDrain, StFetchAddr, StFetchCap, StCsum, StFin
  } state_e;

  // Kind of the byte currently held in byte_q / in flight on the transmitter.
  typedef enum logic [1:0] {KindSync, KindData, KindCsum} kind_e;

  localparam logic [7:0]  LenByte    = 8'(NUM_BINS);
  localparam logic [ADDR_W:0] NumBinsIdx = NUM_BINS[ADDR_W:0];
  localparam logic [ADDR_W:0] IdxOne     = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [7:0]        byte_q, byte_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W-1:0] bin_addr_q, bin_addr_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef FRAMER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    byte_d     = byte_q;
    idx_d      = idx_q;
    bin_addr_d = bin_addr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef FRAMER_CSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (frame_req) begin
          byte_d  = SYNC_BYTE;
          kind_d  = KindSync;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = StSend;
`ifdef FRAMER_CSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      StSend: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_q;
          state_d    = StAccept;
        end
      end
      StAccept: state_d = StDrain;
      StDrain: begin
        if (!tx_busy) begin
          unique case (kind_q)
            KindSync: begin
              byte_d  = LenByte;
              kind_d  = KindData;
              state_d = StSend;
`ifdef FRAMER_CSUM_EN
              csum_d  = csum_q ^ LenByte;
`endif
            end
            KindData: begin
              // idx_q counts bins already captured; it reaches NUM_BINS after the last one.
              if (idx_q < NumBinsIdx) begin
                bin_addr_d = idx_q[ADDR_W-1:0];
                state_d    = StFetchAddr;
              end else begin
`ifdef FRAMER_CSUM_EN
                state_d = StCsum;
`else
                state_d = StFin;
`endif
              end
            end
            KindCsum: state_d = StFin;
            default:  state_d = StIdle;
          endcase
        end
      end
      StFetchAddr: state_d = StFetchCap;
      StFetchCap: begin
        byte_d  = bin_data;
        idx_d   = idx_q + IdxOne;
        state_d = StSend;
`ifdef FRAMER_CSUM_EN
        csum_d  = csum_q ^ bin_data;
`endif
      end
`ifdef FRAMER_CSUM_EN
      StCsum: begin
        byte_d  = csum_q;
        kind_d  = KindCsum;
        state_d = StSend;
      end
`endif
      StFin: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      kind_q     <= KindSync;
      byte_q     <= 8'h00;
      idx_q      <= '0;
      bin_addr_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef FRAMER_CSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      byte_q     <= byte_d;
      idx_q      <= idx_d;
      bin_addr_q <= bin_addr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef FRAMER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bin_addr = bin_addr_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spectrum_uart_framer.sv
// Directed bench for spectrum_uart_framer: instance 0 has 4 bins, instance 1 has 1 bin.
// Each instance gets a synchronous-read RAM and a simple transmitter model that logs bytes.
module tb_spectrum_uart_framer;

  localparam int TX_CYC = 10;
`ifdef FRAMER_CSUM_EN
  localparam int FRAME0 = 7;
  localparam int FRAME1 = 4;
`else
  localparam int FRAME0 = 6;
  localparam int FRAME1 = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_req [2];
  logic [4:0] bin_addr  [2];
  logic [7:0] bin_data  [2];
  logic       tx_start  [2];
  logic [7:0] tx_data   [2];
  logic       tx_busy   [2] = '{1'b0, 1'b0};
  logic       busy      [2];
  logic       done      [2];

  logic [7:0] ram       [2][32];
  int         tx_cnt    [2] = '{0, 0};
  logic [7:0] tx_byte   [2] = '{8'h00, 8'h00};
  logic [7:0] rx_buf    [2][256];
  logic [7:0] rx_n      [2] = '{8'd0, 8'd0};
  int         done_n    [2] = '{0, 0};
  int         viol      [2] = '{0, 0};
  logic       prev_start[2] = '{1'b0, 1'b0};
  logic       chk_stable;

  // 0x04^0x10^0x20^0x30^0x40 = 0x44 ; 0x01^0xFF = 0xFE
  logic [7:0] exp0 [7] = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44};
  logic [7:0] exp1 [4] = '{8'hA5, 8'h01, 8'hFF, 8'hFE};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spectrum_uart_framer #(.NUM_BINS(4), .ADDR_W(5), .SYNC_BYTE(8'hA5)) u_dut0 (
    .clk(clk), .rst(rst), .frame_req(frame_req[0]), .bin_addr(bin_addr[0]),
    .bin_data(bin_data[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .tx_busy(tx_busy[0]), .busy(busy[0]), .done(done[0])
  );

  spectrum_uart_framer #(.NUM_BINS(1), .ADDR_W(5), .SYNC_BYTE(8'hA5)) u_dut1 (
    .clk(clk), .rst(rst), .frame_req(frame_req[1]), .bin_addr(bin_addr[1]),
    .bin_data(bin_data[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .tx_busy(tx_busy[1]), .busy(busy[1]), .done(done[1])
  );

  // RAM + transmitter model; transmitter ignores framer reset and finishes its byte.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bin_data[i] <= ram[i][bin_addr[i]];
      if (tx_busy[i]) begin
        if (tx_cnt[i] == 1) tx_busy[i] <= 1'b0;
        tx_cnt[i] <= tx_cnt[i] - 1;
      end else if (tx_start[i]) begin
        tx_busy[i]          <= 1'b1;
        tx_cnt[i]           <= TX_CYC;
        tx_byte[i]          <= tx_data[i];
        rx_buf[i][rx_n[i]]  <= tx_data[i];
        rx_n[i]             <= rx_n[i] + 8'd1;
      end
      if (done[i]) done_n[i] <= done_n[i] + 1;
    end
  end

  // Protocol watch: start only when idle, one cycle wide, data stable while shifting.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int v;
      v = viol[i];
      if (tx_start[i] && (tx_busy[i] || prev_start[i])) v = v + 1;
      if (chk_stable && tx_busy[i] && (tx_data[i] !== tx_byte[i])) v = v + 1;
      viol[i]       <= v;
      prev_start[i] <= tx_start[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done[i]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_req(input int i);
    frame_req[i] = 1'b1;
    @(negedge clk);
    frame_req[i] = 1'b0;
  endtask

  task automatic check_frame0(input string tag, input logic [7:0] base);
    logic [7:0] p;
    check({tag, "_count"}, 32'(rx_n[0] - base), FRAME0);
    for (int k = 0; k < FRAME0; k++) begin
      p = base + 8'(k);
      check($sformatf("%s_byte%0d", tag, k), 32'(rx_buf[0][p]), 32'(exp0[k]));
    end
  endtask

  initial begin
    logic [7:0] base;
    int         d0;
    bit         ok;

    for (int a = 0; a < 32; a++) begin
      ram[0][a] = 8'h00;
      ram[1][a] = 8'h00;
    end
    ram[0][0] = 8'h10; ram[0][1] = 8'h20; ram[0][2] = 8'h30; ram[0][3] = 8'h40;
    ram[1][0] = 8'hFF;
    rst = 1'b1;
    frame_req[0] = 1'b0;
    frame_req[1] = 1'b0;
    chk_stable = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_tx_start", 32'(tx_start[0]), 0);
    check("rst_tx_data", 32'(tx_data[0]), 0);
    check("rst_bin_addr", 32'(bin_addr[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    check("rst_busy1", 32'(busy[1]), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame.
    base = rx_n[0];
    d0   = done_n[0];
    pulse_req(0);
    check("f1_busy_after_req", 32'(busy[0]), 1);
    wait_done(0, 2000, ok);
    check("f1_done_seen", 32'(ok), 1);
    check("f1_busy_at_done", 32'(busy[0]), 0);
    @(negedge clk);
    check("f1_done_width", 32'(done[0]), 0);
    check("f1_done_count", 32'(done_n[0] - d0), 1);
    check_frame0("f1", base);

    // Request while busy is dropped.
    base = rx_n[0];
    d0   = done_n[0];
    pulse_req(0);
    repeat (40) @(negedge clk);
    pulse_req(0);
    wait_done(0, 2000, ok);
    check("f2_done_seen", 32'(ok), 1);
    repeat (200) @(negedge clk);
    check("f2_done_count", 32'(done_n[0] - d0), 1);
    check("f2_idle_busy", 32'(busy[0]), 0);
    check_frame0("f2", base);
    check("f2_protocol", 32'(viol[0]), 0);

    // Reset while bin 2 is being shifted out.
    base = rx_n[0];
    pulse_req(0);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (rx_n[0] - base == 8'd5) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("f3_reached_bin2", 32'(ok), 1);
    chk_stable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("f3_rst_tx_start", 32'(tx_start[0]), 0);
    check("f3_rst_busy", 32'(busy[0]), 0);
    check("f3_rst_bin_addr", 32'(bin_addr[0]), 0);
    check("f3_tx_still_busy", 32'(tx_busy[0]), 1);
    base = rx_n[0];
    d0   = done_n[0];
    pulse_req(0);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!tx_busy[0]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("f3_tx_went_idle", 32'(ok), 1);
    chk_stable = 1'b1;
    wait_done(0, 2000, ok);
    check("f3_done_seen", 32'(ok), 1);
    @(negedge clk);
    check("f3_done_count", 32'(done_n[0] - d0), 1);
    check_frame0("f3", base);
    check("f3_protocol", 32'(viol[0]), 0);

    // frame_req held high on the single-bin instance: back-to-back frames.
    base = rx_n[1];
    d0   = done_n[1];
    frame_req[1] = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_done(1, 2000, ok);
      check($sformatf("f4_done_seen%0d", f), 32'(ok), 1);
      if (f == 2) frame_req[1] = 1'b0;
      @(negedge clk);
    end
    repeat (100) @(negedge clk);
    check("f4_done_count", 32'(done_n[1] - d0), 3);
    check("f4_count", 32'(rx_n[1] - base), 3 * FRAME1);
    for (int k = 0; k < 3 * FRAME1; k++) begin
      logic [7:0] p;
      p = base + 8'(k);
      check($sformatf("f4_byte%0d", k), 32'(rx_buf[1][p]), 32'(exp1[k % FRAME1]));
    end
    check("f4_idle_busy", 32'(busy[1]), 0);
    check("f4_protocol", 32'(viol[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
